// File: rtl/msx_fdc_multi.sv
// -----------------------------------------------------------------------------
// msx_fdc_multi
//
// Purpose:
//   Register front-end of an MSX disk ROM for 1..4 floppy drives. It sits
//   between the cartridge slot decode and an external WD1793 core. It holds
//   the side, drive-select and motor registers and latches the state of each
//   drive's disk image (mounted, layout, write-protect). It runs the motor-off
//   hold timer, keeps one disk-change flag per drive and sends a resync pulse
//   to the core. It also passes ready/wp/layout of the selected drive to the
//   core.
//
// Parameters:
//   NUM_DRIVES     drives supported (1..4); the select field is always 2 bits
//   MOTOR_HOLD     clock-enable ticks the motor stays on after its bit clears
//   LAYOUT_THRESH  image sizes above this are double-sided (layout 0)
//
// Ports:
//   i_clk              system clock
//   i_reset_n          synchronous reset, active low
//   i_clk_en           CPU-rate enable, used only by the motor timer
//   i_cs               cartridge page select
//   i_addr[13:0]       offset within the page
//   i_d_from_cpu[7:0]  CPU write data
//   o_d_to_cpu[7:0]    CPU read data (combinational)
//   o_output_en        high while this block drives the data bus
//   i_rd / i_wr        CPU strobes, level sensitive, may last several clocks
//   i_img_mounted      one-clock mount/unmount pulse per drive slot
//   i_img_size[31:0]   size of the image being mounted (0 = eject)
//   i_img_readonly     read-only flag of the image being mounted
//   o_wd_cs            WD1793 register window select (3FF8..3FFB)
//   i_wd_dout[7:0]     WD1793 read data
//   i_wd_drq           WD1793 data request
//   i_wd_intrq         WD1793 interrupt request
//   o_wd_ready         ready of the selected drive to the core
//   o_wd_wp            write-protect of the selected drive
//   o_wd_layout        layout of the selected drive
//   o_wd_side          side register bit 0
//   o_wd_img_mounted   one-clock resync pulse to the core
//   o_drive_sel[1:0]   currently selected drive
//   o_motor_on         effective motor state
// -----------------------------------------------------------------------------
module msx_fdc_multi #(
   parameter int          NUM_DRIVES    = 2,
   parameter logic [23:0] MOTOR_HOLD    = 24'd7159090,
   parameter logic [31:0] LAYOUT_THRESH = 32'h5A000
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_clk_en,
   input  logic                  i_cs,
   input  logic [13:0]           i_addr,
   input  logic [7:0]            i_d_from_cpu,
   output logic [7:0]            o_d_to_cpu,
   output logic                  o_output_en,
   input  logic                  i_rd,
   input  logic                  i_wr,
   input  logic [NUM_DRIVES-1:0] i_img_mounted,
   input  logic [31:0]           i_img_size,
   input  logic                  i_img_readonly,
   output logic                  o_wd_cs,
   input  logic [7:0]            i_wd_dout,
   input  logic                  i_wd_drq,
   input  logic                  i_wd_intrq,
   output logic                  o_wd_ready,
   output logic                  o_wd_wp,
   output logic                  o_wd_layout,
   output logic                  o_wd_side,
   output logic                  o_wd_img_mounted,
   output logic [1:0]            o_drive_sel,
   output logic                  o_motor_on
);

   localparam logic [2:0] NUM_D3 = 3'(NUM_DRIVES);

   logic [7:0]  r_sideReg;
   logic [7:0]  r_driveReg;
   logic [3:0]  r_mounted;
   logic [3:0]  r_layout;
   logic [3:0]  r_wp;
   logic [3:0]  r_changed;
   logic [3:0]  r_chgHold;
   logic        r_chgRdDly;
   logic        r_motorOn;
   logic [23:0] r_timer;
   logic        r_wdImgMounted;
   logic [1:0]  r_prevSel;

   logic [3:0]  w_mountPulse;
   logic        w_page;
   logic        w_wdHit;
   logic        w_sideHit;
   logic        w_driveHit;
   logic        w_chgHit;
   logic        w_statHit;
   logic        w_chgRd;
   logic        w_chgRdRise;
   logic        w_chgHoldActive;
   logic [1:0]  w_sel;
   logic        w_selValid;
   logic        w_readyInt;
   logic        w_sizeNonZero;
   logic        w_sizeSingle;
   logic        w_anyHit;

   // The mount pulses are widened to four slots. Slots above NUM_DRIVES are
   // tied low, so the per-drive state of a missing drive stays zero for good.
   genvar gd;
   for (gd = 0; gd < 4; gd++) begin : g_slot
      if (gd < NUM_DRIVES) begin : g_present
         assign w_mountPulse[gd] = i_img_mounted[gd];
      end else begin : g_absent
         assign w_mountPulse[gd] = 1'b0;
      end
   end

   // Address decode for the top eight bytes of the page. 3FF8..3FFB belong
   // to the WD1793. The four bytes above them are the local registers.
   assign w_page      = i_cs && (i_addr[13:3] == 11'h7FF);
   assign w_wdHit     = w_page && !i_addr[2];
   assign w_sideHit   = w_page && (i_addr[2:0] == 3'd4);
   assign w_driveHit  = w_page && (i_addr[2:0] == 3'd5);
   assign w_chgHit    = w_page && (i_addr[2:0] == 3'd6);
   assign w_statHit   = w_page && (i_addr[2:0] == 3'd7);

   // A read of the change register clears the flags once per strobe, on its
   // rising edge. While the strobe stays high, the read data comes from a
   // copy taken at that edge, so the CPU sees the value from before the clear.
   assign w_chgRd         = w_chgHit && i_rd;
   assign w_chgRdRise     = w_chgRd && !r_chgRdDly;
   assign w_chgHoldActive = w_chgRd && r_chgRdDly;

   // A select value that names a drive which does not exist acts as "no
   // drive": never ready, never protected, and reports single-sided layout.
   assign w_sel         = r_driveReg[1:0];
   assign w_selValid    = ({1'b0, w_sel} < NUM_D3);
   assign w_readyInt    = w_selValid && r_mounted[w_sel] && r_motorOn;
   assign w_sizeNonZero = (i_img_size != 32'd0);
   assign w_sizeSingle  = (i_img_size <= LAYOUT_THRESH);

   // CPU read mux. Any page address outside the register window leaves the
   // bus alone. The drive register reads back with bit 2 masked.
   always_comb begin
      o_d_to_cpu = 8'hFF;
      w_anyHit   = 1'b0;
      if (w_wdHit) begin
         o_d_to_cpu = i_wd_dout;
         w_anyHit   = 1'b1;
      end else if (w_sideHit) begin
         o_d_to_cpu = r_sideReg;
         w_anyHit   = 1'b1;
      end else if (w_driveHit) begin
         o_d_to_cpu = r_driveReg & 8'hFB;
         w_anyHit   = 1'b1;
      end else if (w_chgHit) begin
         o_d_to_cpu = {4'b1111, (w_chgHoldActive ? r_chgHold : r_changed)};
         w_anyHit   = 1'b1;
      end else if (w_statHit) begin
         o_d_to_cpu = {~i_wd_drq, ~i_wd_intrq, ~w_readyInt, 5'b11111};
         w_anyHit   = 1'b1;
      end
   end

   assign o_output_en = w_anyHit && i_rd;
   assign o_wd_cs     = w_wdHit;

   // The side and drive registers take the CPU write on every clock that
   // the strobe is high. A long strobe therefore keeps the last value.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_sideReg  <= 8'h00;
         r_driveReg <= 8'h00;
      end else begin
         if (i_wr && w_sideHit) begin
            r_sideReg <= i_d_from_cpu;
         end
         if (i_wr && w_driveHit) begin
            r_driveReg <= i_d_from_cpu;
         end
      end
   end

   // Per-drive image state and change flags. All slots pulsed in the same
   // clock latch the same size and read-only flag. A mount pulse that lands
   // on the same clock as a change-register clear wins, so no mount is lost.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_mounted  <= 4'b0000;
         r_layout   <= 4'b0000;
         r_wp       <= 4'b0000;
         r_changed  <= 4'b0000;
         r_chgHold  <= 4'b0000;
         r_chgRdDly <= 1'b0;
      end else begin
         r_mounted  <= (r_mounted & ~w_mountPulse) | (w_mountPulse & {4{w_sizeNonZero}});
         r_layout   <= (r_layout  & ~w_mountPulse) | (w_mountPulse & {4{w_sizeSingle}});
         r_wp       <= (r_wp      & ~w_mountPulse) | (w_mountPulse & {4{i_img_readonly}});
         r_changed  <= (w_chgRdRise ? 4'b0000 : r_changed) | w_mountPulse;
         r_chgRdDly <= w_chgRd;
         if (w_chgRdRise) begin
            r_chgHold <= r_changed;
         end
      end
   end

   // Motor hold. The motor bit holds the timer at its reload value. Once the
   // bit clears, the timer counts down on clock-enable ticks and stops at
   // zero. The clock after it reaches zero turns the motor off, so a zero
   // hold time gives one clock of latency.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_motorOn <= 1'b0;
         r_timer   <= 24'd0;
      end else if (r_driveReg[7]) begin
         r_motorOn <= 1'b1;
         r_timer   <= MOTOR_HOLD;
      end else if (r_motorOn) begin
         if (r_timer == 24'd0) begin
            r_motorOn <= 1'b0;
         end else if (i_clk_en) begin
            r_timer <= r_timer - 24'd1;
         end
      end
   end

   // Core resync. Pulse for one clock when the selected drive gets a mount
   // event or when the selection changes. If both happen together, the two
   // causes are OR-ed into a single pulse.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wdImgMounted <= 1'b0;
         r_prevSel      <= 2'd0;
      end else begin
         r_wdImgMounted <= w_mountPulse[w_sel] || (w_sel != r_prevSel);
         r_prevSel      <= w_sel;
      end
   end

   assign o_wd_ready       = w_readyInt;
   assign o_wd_wp          = w_selValid && r_wp[w_sel];
   assign o_wd_layout      = !w_selValid || r_layout[w_sel];
   assign o_wd_side        = r_sideReg[0];
   assign o_wd_img_mounted = r_wdImgMounted;
   assign o_drive_sel      = w_sel;
   assign o_motor_on       = r_motorOn;

endmodule

// File: tb/tb_msx_fdc_multi.sv
// -----------------------------------------------------------------------------
// tb_msx_fdc_multi
//
// Purpose:
//   Self-checking bench for msx_fdc_multi. It runs two drives with a short
//   motor hold of 5 ticks. A behavioural model tracks the drive images,
//   change flags, registers and motor state, and each scenario task compares
//   the design outputs against it.
// -----------------------------------------------------------------------------
module tb_msx_fdc_multi;

   localparam logic [31:0] THRESH = 32'h5A000;

   logic        clk = 1'b0;
   logic        resetN;
   logic        clkEn;
   logic        cs;
   logic [13:0] addr;
   logic [7:0]  dFromCpu;
   logic [7:0]  dToCpu;
   logic        outputEn;
   logic        rd;
   logic        wr;
   logic [1:0]  imgMounted;
   logic [31:0] imgSize;
   logic        imgReadonly;
   logic        wdCs;
   logic [7:0]  wdDout;
   logic        wdDrq;
   logic        wdIntrq;
   logic        wdReady;
   logic        wdWp;
   logic        wdLayout;
   logic        wdSide;
   logic        wdImgMounted;
   logic [1:0]  driveSel;
   logic        motorOn;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [3:0] mMounted;
   logic [3:0] mLayout;
   logic [3:0] mWp;
   logic [3:0] mChanged;
   logic [7:0] mDrive;
   logic [7:0] mSide;
   logic       mMotor;

   always #5 clk = ~clk;

   msx_fdc_multi #(
      .NUM_DRIVES   (2),
      .MOTOR_HOLD   (24'd5),
      .LAYOUT_THRESH(THRESH)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (resetN),
      .i_clk_en        (clkEn),
      .i_cs            (cs),
      .i_addr          (addr),
      .i_d_from_cpu    (dFromCpu),
      .o_d_to_cpu      (dToCpu),
      .o_output_en     (outputEn),
      .i_rd            (rd),
      .i_wr            (wr),
      .i_img_mounted   (imgMounted),
      .i_img_size      (imgSize),
      .i_img_readonly  (imgReadonly),
      .o_wd_cs         (wdCs),
      .i_wd_dout       (wdDout),
      .i_wd_drq        (wdDrq),
      .i_wd_intrq      (wdIntrq),
      .o_wd_ready      (wdReady),
      .o_wd_wp         (wdWp),
      .o_wd_layout     (wdLayout),
      .o_wd_side       (wdSide),
      .o_wd_img_mounted(wdImgMounted),
      .o_drive_sel     (driveSel),
      .o_motor_on      (motorOn)
   );

   // Step to one time unit after the next rising edge. Outputs are sampled
   // there and inputs are changed there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      mMounted = 4'b0; mLayout = 4'b0; mWp = 4'b0; mChanged = 4'b0;
      mDrive = 8'h00; mSide = 8'h00; mMotor = 1'b0;
   endtask

   function automatic logic expReadyF();
      int s;
      s = int'(mDrive[1:0]);
      return (s < 2) && mMounted[s] && mMotor;
   endfunction

   function automatic logic expWpF();
      int s;
      s = int'(mDrive[1:0]);
      return (s < 2) && mWp[s];
   endfunction

   function automatic logic expLayoutF();
      int s;
      s = int'(mDrive[1:0]);
      return (s >= 2) || mLayout[s];
   endfunction

   function automatic logic [31:0] pickSize();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return THRESH;
         2:       return THRESH + 32'd1;
         default: return $urandom();
      endcase
   endfunction

   // Pulse one or more drive slots for a single clock and update the model.
   task automatic doMount(input logic [1:0] mask, input logic [31:0] size, input logic ro);
      imgMounted = mask; imgSize = size; imgReadonly = ro;
      tick();
      imgMounted = 2'b00;
      for (int d = 0; d < 2; d++) begin
         if (mask[d]) begin
            mMounted[d] = (size != 0);
            mLayout[d]  = (size <= THRESH);
            mWp[d]      = ro;
            mChanged[d] = 1'b1;
         end
      end
   endtask

   task automatic cpuWrite(input logic [13:0] a, input logic [7:0] d, input int hold);
      cs = 1'b1; addr = a; dFromCpu = d; wr = 1'b1;
      repeat (hold) tick();
      wr = 1'b0; cs = 1'b0;
   endtask

   // Hold a read strobe for 'hold' clocks. Return the data at the start and
   // at the end of the strobe, plus output-enable and core-select at the start.
   task automatic cpuRead(input logic [13:0] a, input int hold, output logic [7:0] first,
                          output logic [7:0] last, output logic oe, output logic wcs);
      cs = 1'b1; addr = a; rd = 1'b1;
      #1;
      first = dToCpu; oe = outputEn; wcs = wdCs;
      repeat (hold) tick();
      last = dToCpu;
      rd = 1'b0; cs = 1'b0;
      tick();
   endtask

   task automatic countPulses(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         if (wdImgMounted === 1'b1) cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [7:0] f, l;
      logic oe, wc;
      resetN = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; imgMounted = 2'b00; clkEn = 1'b0;
      wdDrq = 1'b0; wdIntrq = 1'b0; addr = 14'h0; dFromCpu = 8'h00; imgSize = 32'd0;
      imgReadonly = 1'b0; wdDout = 8'h00;
      repeat (3) tick();
      resetN = 1'b1;
      modelReset();
      checks++; if (motorOn !== 1'b0) begin errors++; $display("[TB] FAIL reset_motor got %b exp 0", motorOn); end
      checks++; if (wdReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b exp 0", wdReady); end
      checks++; if (driveSel !== 2'd0) begin errors++; $display("[TB] FAIL reset_sel got %0d exp 0", driveSel); end
      checks++; if (wdImgMounted !== 1'b0) begin errors++; $display("[TB] FAIL reset_resync got %b exp 0", wdImgMounted); end
      checks++; if ({wdWp, wdLayout, wdSide} !== 3'b000) begin errors++; $display("[TB] FAIL reset_wp_lay_side got %b exp 000", {wdWp, wdLayout, wdSide}); end
      checks++; if (outputEn !== 1'b0 || dToCpu !== 8'hFF) begin errors++; $display("[TB] FAIL reset_idle_bus got oe=%b d=%h exp oe=0 d=ff", outputEn, dToCpu); end
      cpuRead(14'h3FFF, 1, f, l, oe, wc);
      checks++; if (f !== 8'hFF || oe !== 1'b1) begin errors++; $display("[TB] FAIL reset_status got d=%h oe=%b exp d=ff oe=1", f, oe); end
      cpuRead(14'h3FFD, 1, f, l, oe, wc);
      checks++; if (f !== 8'h00) begin errors++; $display("[TB] FAIL reset_drivereg got %h exp 00", f); end
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF0) begin errors++; $display("[TB] FAIL reset_change got %h exp f0", f); end
   endtask

   task automatic test_mount_select();
      logic [7:0] f, l;
      logic oe, wc;
      int n;
      doMount(2'b10, THRESH, 1'b1);
      cpuWrite(14'h3FFD, 8'h81, 1);
      mDrive = 8'h81; mMotor = 1'b1;
      countPulses(6, n);
      checks++; if (n != 1) begin errors++; $display("[TB] FAIL select_resync_pulses got %0d exp 1", n); end
      checks++; if ({wdReady, wdWp, wdLayout} !== 3'b111) begin errors++; $display("[TB] FAIL select_rdy_wp_lay got %b exp 111", {wdReady, wdWp, wdLayout}); end
      checks++; if (driveSel !== 2'd1 || motorOn !== 1'b1) begin errors++; $display("[TB] FAIL select_sel_motor got sel=%0d m=%b exp sel=1 m=1", driveSel, motorOn); end
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF2 || oe !== 1'b1) begin errors++; $display("[TB] FAIL change_first got d=%h oe=%b exp d=f2 oe=1", f, oe); end
      mChanged = 4'b0;
      cpuRead(14'h3FFE, 2, f, l, oe, wc);
      checks++; if (f !== 8'hF0 || l !== 8'hF0) begin errors++; $display("[TB] FAIL change_second got %h/%h exp f0/f0", f, l); end
      // Ejecting the selected drive must resync the core once
      doMount(2'b10, 32'd0, 1'b0);
      countPulses(4, n);
      checks++; if (n != 1) begin errors++; $display("[TB] FAIL eject_resync_pulses got %0d exp 1", n); end
      checks++; if ({wdReady, wdWp, wdLayout} !== 3'b001) begin errors++; $display("[TB] FAIL eject_rdy_wp_lay got %b exp 001", {wdReady, wdWp, wdLayout}); end
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF2) begin errors++; $display("[TB] FAIL eject_change got %h exp f2", f); end
      mChanged = 4'b0;
   endtask

   task automatic test_motor();
      int ticks;
      logic expOn;
      logic en;
      clkEn = 1'b0;
      doMount(2'b01, 32'hB4000, 1'b0);
      cpuWrite(14'h3FFD, 8'h80, $urandom_range(1, 3));
      mDrive = 8'h80;
      tick();
      mMotor = 1'b1;
      checks++; if ({motorOn, wdReady, wdLayout, wdWp} !== 4'b1100) begin errors++; $display("[TB] FAIL motor_on_drive0 got %b exp 1100", {motorOn, wdReady, wdLayout, wdWp}); end
      // Start a countdown, spend 3 ticks of it, then set the motor bit again
      cpuWrite(14'h3FFD, 8'h00, 1);
      clkEn = 1'b1;
      repeat (3) tick();
      clkEn = 1'b0;
      checks++; if (motorOn !== 1'b1) begin errors++; $display("[TB] FAIL motor_mid_countdown got %b exp 1", motorOn); end
      cpuWrite(14'h3FFD, 8'h80, 1);
      clkEn = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (motorOn !== 1'b1) begin errors++; $display("[TB] FAIL motor_hold_reload cycle %0d got %b exp 1", c, motorOn); end
      end
      clkEn = 1'b0;
      // Full countdowns: random enables first, then steady enables. The
      // second run must take the whole hold time again, because the rewrite
      // reloaded the timer.
      for (int phase = 0; phase < 2; phase++) begin
         cpuWrite(14'h3FFD, 8'h00, 1);
         mDrive = 8'h00;
         ticks = 0;
         expOn = 1'b1;
         for (int c = 0; c < 40; c++) begin
            en = (phase == 1 || c >= 25) ? 1'b1 : 1'($urandom_range(0, 1));
            clkEn = en;
            if (ticks == 5) expOn = 1'b0;
            else if (en) ticks++;
            tick();
            checks++; if (motorOn !== expOn || wdReady !== expOn) begin errors++; $display("[TB] FAIL motor_countdown p%0d c%0d got m=%b r=%b exp %b", phase, c, motorOn, wdReady, expOn); end
         end
         clkEn = 1'b0;
         mMotor = 1'b0;
         if (phase == 0) begin
            cpuWrite(14'h3FFD, 8'h80, 1);
            tick();
            mDrive = 8'h80; mMotor = 1'b1;
         end
      end
   endtask

   task automatic test_clear_collision();
      logic [7:0] f, l, expOld;
      logic oe, wc;
      logic [31:0] sz;
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== {4'hF, mChanged}) begin errors++; $display("[TB] FAIL collide_pre got %h exp %h", f, {4'hF, mChanged}); end
      mChanged = 4'b0;
      doMount(2'b10, pickSize(), 1'($urandom_range(0, 1)));
      expOld = {4'hF, mChanged};
      // Read strobe rises in the same clock as a mount pulse on drive 0
      sz = pickSize();
      cs = 1'b1; addr = 14'h3FFE; rd = 1'b1;
      imgMounted = 2'b01; imgSize = sz; imgReadonly = 1'b1;
      #1;
      checks++; if (dToCpu !== expOld) begin errors++; $display("[TB] FAIL collide_rise got %h exp %h", dToCpu, expOld); end
      tick();
      imgMounted = 2'b00;
      mMounted[0] = (sz != 0); mLayout[0] = (sz <= THRESH); mWp[0] = 1'b1;
      mChanged = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         checks++; if (dToCpu !== expOld) begin errors++; $display("[TB] FAIL collide_hold c%0d got %h exp %h", c, dToCpu, expOld); end
         tick();
      end
      rd = 1'b0; cs = 1'b0;
      tick();
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF1) begin errors++; $display("[TB] FAIL collide_after got %h exp f1", f); end
      mChanged = 4'b0;
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF0) begin errors++; $display("[TB] FAIL collide_cleared got %h exp f0", f); end
   endtask

   task automatic test_invalid_select();
      logic [7:0] f, l;
      logic oe, wc;
      doMount(2'b01, THRESH + 32'd1 + ($urandom() & 32'hFFFF), 1'b1);
      cpuWrite(14'h3FFD, 8'h83, 1);
      tick();
      mDrive = 8'h83; mMotor = 1'b1;
      checks++; if (driveSel !== 2'd3 || motorOn !== 1'b1) begin errors++; $display("[TB] FAIL invsel_sel_motor got sel=%0d m=%b exp sel=3 m=1", driveSel, motorOn); end
      checks++; if ({wdReady, wdWp, wdLayout} !== 3'b001) begin errors++; $display("[TB] FAIL invsel3_rdy_wp_lay got %b exp 001", {wdReady, wdWp, wdLayout}); end
      cpuRead(14'h3FFD, 1, f, l, oe, wc);
      checks++; if (f !== 8'h83) begin errors++; $display("[TB] FAIL invsel_read83 got %h exp 83", f); end
      cpuWrite(14'h3FFD, 8'h07, 2);
      mDrive = 8'h07;
      cpuRead(14'h3FFD, 1, f, l, oe, wc);
      checks++; if (f !== 8'h03 || driveSel !== 2'd3) begin errors++; $display("[TB] FAIL invsel_read07 got d=%h sel=%0d exp d=03 sel=3", f, driveSel); end
      cpuWrite(14'h3FFD, 8'h02, 1);
      mDrive = 8'h02;
      checks++; if ({wdReady, wdWp, wdLayout} !== 3'b001) begin errors++; $display("[TB] FAIL invsel2_rdy_wp_lay got %b exp 001", {wdReady, wdWp, wdLayout}); end
      cpuWrite(14'h3FFD, 8'h00, 1);
      mDrive = 8'h00;
      checks++; if ({wdReady, wdWp, wdLayout} !== 3'b110) begin errors++; $display("[TB] FAIL invsel_back0 got %b exp 110", {wdReady, wdWp, wdLayout}); end
   endtask

   task automatic test_random();
      logic [7:0] f, l, v, expD;
      logic [13:0] a;
      logic oe, wc, expOe, expCs;
      int sel;
      clkEn = 1'b0;
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 3))
            0: doMount(2'($urandom_range(0, 3)), pickSize(), 1'($urandom_range(0, 1)));
            1: begin
               v = 8'($urandom());
               cpuWrite(14'h3FFC, v, $urandom_range(1, 3));
               mSide = v;
            end
            2: begin
               v = 8'($urandom());
               cpuWrite(14'h3FFD, v, $urandom_range(1, 3));
               tick();
               mDrive = v;
               if (v[7]) mMotor = 1'b1;
            end
            default: begin
               wdDout = 8'($urandom()); wdDrq = 1'($urandom_range(0, 1)); wdIntrq = 1'($urandom_range(0, 1));
               sel = $urandom_range(0, 5);
               expOe = 1'b1; expCs = 1'b0;
               case (sel)
                  0: begin a = 14'h3FFC; expD = mSide; end
                  1: begin a = 14'h3FFD; expD = mDrive & 8'hFB; end
                  2: begin a = 14'h3FFE; expD = {4'hF, mChanged}; end
                  3: begin a = 14'h3FFF; expD = {~wdDrq, ~wdIntrq, ~expReadyF(), 5'b11111}; end
                  4: begin a = 14'h3FF8 + 14'($urandom_range(0, 3)); expD = wdDout; expCs = 1'b1; end
                  default: begin a = 14'($urandom_range(0, 16375)); expD = 8'hFF; expOe = 1'b0; end
               endcase
               cpuRead(a, $urandom_range(1, 3), f, l, oe, wc);
               checks++; if (f !== expD || l !== expD || oe !== expOe || wc !== expCs) begin errors++; $display("[TB] FAIL rand_read addr=%h got d=%h/%h oe=%b cs=%b exp d=%h oe=%b cs=%b", a, f, l, oe, wc, expD, expOe, expCs); end
               if (sel == 2) mChanged = 4'b0;
            end
         endcase
         checks++; if ({driveSel, wdSide, motorOn} !== {mDrive[1:0], mSide[0], mMotor}) begin errors++; $display("[TB] FAIL rand_regs it%0d got %b exp %b", it, {driveSel, wdSide, motorOn}, {mDrive[1:0], mSide[0], mMotor}); end
         checks++; if ({wdReady, wdWp, wdLayout} !== {expReadyF(), expWpF(), expLayoutF()}) begin errors++; $display("[TB] FAIL rand_drive it%0d got %b exp %b", it, {wdReady, wdWp, wdLayout}, {expReadyF(), expWpF(), expLayoutF()}); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] f, l;
      logic oe, wc;
      doMount(2'b11, THRESH - 32'd1, 1'b1);
      cpuWrite(14'h3FFC, 8'hFF, 1);
      cpuWrite(14'h3FFD, 8'h81, 1);
      tick();
      cpuWrite(14'h3FFD, 8'h01, 1);
      clkEn = 1'b1;
      repeat (2) tick();
      checks++; if (motorOn !== 1'b1 || wdReady !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre got m=%b r=%b exp 1/1", motorOn, wdReady); end
      resetN = 1'b0;
      tick();
      modelReset();
      checks++; if ({motorOn, wdReady, wdSide, wdWp, wdLayout} !== 5'b0) begin errors++; $display("[TB] FAIL midreset_flags got %b exp 00000", {motorOn, wdReady, wdSide, wdWp, wdLayout}); end
      checks++; if (driveSel !== 2'd0 || outputEn !== 1'b0 || dToCpu !== 8'hFF) begin errors++; $display("[TB] FAIL midreset_bus got sel=%0d oe=%b d=%h exp 0/0/ff", driveSel, outputEn, dToCpu); end
      resetN = 1'b1;
      repeat (8) tick();
      checks++; if (motorOn !== 1'b0 || wdImgMounted !== 1'b0) begin errors++; $display("[TB] FAIL midreset_timer got m=%b p=%b exp 0/0", motorOn, wdImgMounted); end
      clkEn = 1'b0;
      cpuRead(14'h3FFE, 1, f, l, oe, wc);
      checks++; if (f !== 8'hF0) begin errors++; $display("[TB] FAIL midreset_change got %h exp f0", f); end
      cpuRead(14'h3FFC, 1, f, l, oe, wc);
      checks++; if (f !== 8'h00) begin errors++; $display("[TB] FAIL midreset_side got %h exp 00", f); end
   endtask

   // Sequence the scenarios, then report
   initial begin
      test_reset();
      test_mount_select();
      test_motor();
      test_clear_collision();
      test_invalid_select();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog against a stuck run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout exp finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
